// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the minicpu datapath.
// Drives the active-low register load strobes, the mux/ALU selects and the instruction memory handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// state   | meaning
// IDLE    | waiting for a start pulse
// FETCH   | instruction read outstanding; IR/PC load in the ack cycle
// DECODE  | one settling cycle while the new IR propagates
// EXECUTE | opcode action; retires the instruction
// HALT    | stopped until reset
module cpu_sequencer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  zero,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  ld_pc_n,
  output logic                  ld_ir_n,
  output logic                  ld_a_n,
  output logic                  ld_b_n,
  output logic                  ld_out_n,
  output logic                  pc_sel,
  output logic                  a_sel,
  output logic                  alu_op,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t               r_state;
  state_t               w_next;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_retired;
  logic [3:0]           w_opcode;
  logic                 w_op_undef;
  logic                 w_exec;
  logic                 w_unused_imm;

  assign w_opcode     = ir[DATA_WIDTH-1 -: 4];
  // The immediate is consumed by the datapath, not here.
  assign w_unused_imm = ^ir[DATA_WIDTH-5:0];
  assign w_op_undef   = (w_opcode >= 4'h8) && (w_opcode != OP_HLT);
  assign w_exec       = (r_state == S_EXECUTE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else if (w_exec) begin
      r_retired <= r_retired + CNT_WIDTH'(1);
      if (w_op_undef) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    ld_pc_n  = 1'b1;
    ld_ir_n  = 1'b1;
    ld_a_n   = 1'b1;
    ld_b_n   = 1'b1;
    ld_out_n = 1'b1;
    pc_sel   = 1'b0;
    a_sel    = 1'b0;
    alu_op   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_ir_n = 1'b0;
          ld_pc_n = 1'b0;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_next = S_FETCH;
        case (w_opcode)
          OP_NOP: ;
          OP_LDA: ld_a_n = 1'b0;
          OP_LDB: ld_b_n = 1'b0;
          OP_ADD: begin
            ld_a_n = 1'b0;
            a_sel  = 1'b1;
          end
          OP_SUB: begin
            ld_a_n = 1'b0;
            a_sel  = 1'b1;
            alu_op = 1'b1;
          end
          OP_OUT: ld_out_n = 1'b0;
          OP_JMP: begin
            ld_pc_n = 1'b0;
            pc_sel  = 1'b1;
          end
          OP_JZ: begin
            if (zero) begin
              ld_pc_n = 1'b0;
              pc_sel  = 1'b1;
            end
          end
          OP_HLT: w_next = S_HALT;
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: models IR loading and predicts the EXECUTE strobes per opcode.
// Built with CNT_WIDTH = 4 so retired-counter wrap is reachable.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ir;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, ld_pc_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n;
  logic       pc_sel, a_sel, alu_op, halted, illegal;
  logic [3:0] retired;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [3:0] exp_ret;
  logic       exp_ill;
  logic [9:0] exp_q[$];

  // {ld_pc_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n, pc_sel, a_sel, alu_op, mem_req, halted}
  localparam logic [9:0] V_IDLE  = 10'b11111_000_00;
  localparam logic [9:0] V_WAIT  = 10'b11111_000_10;
  localparam logic [9:0] V_ACK   = 10'b00111_000_10;
  localparam logic [9:0] V_HALT  = 10'b11111_000_01;

  cpu_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .ld_pc_n(ld_pc_n), .ld_ir_n(ld_ir_n),
    .ld_a_n(ld_a_n), .ld_b_n(ld_b_n), .ld_out_n(ld_out_n), .pc_sel(pc_sel),
    .a_sel(a_sel), .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs();
    return {ld_pc_n, ld_ir_n, ld_a_n, ld_b_n, ld_out_n, pc_sel, a_sel, alu_op, mem_req, halted};
  endfunction

  function automatic logic [9:0] exp_exec(input logic [3:0] op, input logic z);
    logic [9:0] v;
    v = V_IDLE;
    case (op)
      4'h1: v[7] = 1'b0;
      4'h2: v[6] = 1'b0;
      4'h3: begin v[7] = 1'b0; v[3] = 1'b1; end
      4'h4: begin v[7] = 1'b0; v[3] = 1'b1; v[2] = 1'b1; end
      4'h5: v[5] = 1'b0;
      4'h6: begin v[9] = 1'b0; v[4] = 1'b1; end
      4'h7: if (z) begin v[9] = 1'b0; v[4] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; zero = 1'b0; ir = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", outs(), V_IDLE);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;
    exp_ret = 4'd0;
    exp_ill = 1'b0;
  endtask

  // Leaves the DUT one cycle into FETCH, 1 time unit after the edge.
  task automatic start_seq();
    @(negedge clk);
    check("idle_outs", outs(), V_IDLE);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered 1 unit after an edge with the DUT in FETCH.
  task automatic run_instr(input logic [7:0] instr, input int w, input logic z,
                           input logic poke_start, input logic abort);
    int         reqs;
    logic [9:0] got;
    logic [9:0] e;
    reqs = 0;
    check("retired", retired, exp_ret);
    check("illegal", illegal, exp_ill);
    exp_q.push_back(exp_exec(instr[7:4], z));
    for (int i = 0; i <= w; i++) begin
      mem_ack = (i == w);
      start   = poke_start;
      @(negedge clk);
      if (mem_req) reqs++;
      if (i == w) check("ack_cycle", outs(), V_ACK);
      else        check("fetch_wait", outs(), V_WAIT);
      @(posedge clk);
      #1;
    end
    check("req_cycles", reqs, w + 1);
    // IR captured at the ack edge; a stray ack in DECODE must be ignored.
    ir      = instr;
    mem_ack = 1'b1;
    @(negedge clk);
    check("decode", outs(), V_IDLE);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    start   = 1'b0;
    zero    = z;
    @(negedge clk);
    got = outs();
    e   = exp_q.pop_front();
    check("exec", got, e);
    if (abort) begin
      #1 reset = 1'b1;
      #1;
      check("rst_exec_outs", outs(), V_IDLE);
      check("rst_exec_ret", retired, 0);
      return;
    end
    exp_ret = exp_ret + 4'd1;
    if (instr[7:4] >= 4'h8 && instr[7:4] != 4'hF) exp_ill = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] op;
    // program: LDA 3, LDB 2, ADD, OUT, HLT
    do_reset();
    start_seq();
    run_instr(8'h13, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h22, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h30, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h50, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'hF0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start = (i < 2);
      @(negedge clk);
      check("halt_outs", outs(), V_HALT);
      check("halt_retired", retired, 5);
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // delayed ack, JZ taken / not taken, illegal opcode stickiness
    do_reset();
    start_seq();
    run_instr(8'h13, 4, 1'b0, 1'b0, 1'b0);
    run_instr(8'h75, 0, 1'b1, 1'b0, 1'b0);
    run_instr(8'h76, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h90, 0, 1'b0, 1'b0, 1'b0);
    run_instr(8'h13, 1, 1'b0, 1'b0, 1'b0);
    run_instr(8'h40, 0, 1'b1, 1'b0, 1'b0);
    run_instr(8'h6A, 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      op = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      run_instr(op, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // async reset mid-FETCH wait
    mem_ack = 1'b0;
    @(negedge clk);
    check("fetch_pre_rst", outs(), V_WAIT);
    #1 reset = 1'b1;
    #1;
    check("rst_fetch_outs", outs(), V_IDLE);
    check("rst_fetch_ret", retired, 0);
    check("rst_fetch_ill", illegal, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ret = 4'd0;
    exp_ill = 1'b0;
    start_seq();
    run_instr(8'h13, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ret = 4'd0;
    exp_ill = 1'b0;
    start_seq();
    run_instr(8'h22, 1, 1'b0, 1'b0, 1'b0);

    // retired wrap with start pulses in FETCH/DECODE
    do_reset();
    start_seq();
    for (int i = 0; i < 17; i++) begin
      run_instr(8'h00, i % 2, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    check("wrap_retired", retired, 1);
    check("wrap_fetch", outs(), V_WAIT);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
